axi_thread_tracker: RTL

- Per-master open-transaction table for one AXI4 crossbar master port (one instance for the read channel, one for the write channel).
- Holds up to NUM_THREADS concurrently open IDs, each bound to a single target slave with an outstanding count.
- Supplies threadAvail, threadValid, threadCount and threadSlaveID to the dependence checker, so a new request for an open ID is only qualified to the same slave and below OPEN_TRANS_MAX.
- Counts up on address acceptance and down on response completion.

---
 rtl/axi_thread_tracker.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/axi_thread_tracker.sv
// ---------------------------------------------------------------------------
// axi_thread_tracker
//
// Open-transaction table for one AXI4 crossbar master port (use one instance
// for the read channel and one for the write channel). Each slot binds an
// open transaction ID to one target slave and keeps an outstanding count.
// The dependence checker uses the lookup outputs so that a new request for
// an already-open ID can only go to the same slave, and only while that ID
// is below OPEN_TRANS_MAX outstanding transactions.
//
// Handshake: openTransInc and openTransDec are single-cycle pulses sampled
// on the rising edge of sysClk. An inc means the request now presented on
// currTransID/currTransSlaveID was accepted. A dec means the last beat of
// the response for openTransDecID completed. There is no back-pressure.
// Both pulses are evaluated against the table state at the start of the
// cycle. Their effects show on the lookup outputs from the next cycle.
//
// Ports:
//   sysClk            clock; all state updates on the rising edge
//   sysReset          asynchronous, active-low reset
//   currTransID       ID of the request currently presented
//   currTransSlaveID  decoded target slave of that request
//   openTransInc      pulse: current request accepted
//   openTransDec      pulse: transaction openTransDecID completed
//   openTransDecID    ID of the completing transaction
//   threadAvail       at least one free slot
//   threadValid       currTransID matches an open slot
//   threadCount       outstanding count of the matched slot (0 if no match)
//   threadSlaveID     slave of the matched slot (0 if no match)
//   openTransAny      any slot open
//   trackErr          sticky protocol-error flag; only reset clears it
// ---------------------------------------------------------------------------
module axi_thread_tracker #(
  parameter int NUM_THREADS      = 4,
  parameter int NUM_SLAVES       = 4,
  parameter int NUM_SLAVES_WIDTH = 2,
  parameter int MASTERID_WIDTH   = 4,
  parameter int OPEN_TRANS_MAX   = 3,
  parameter int OPEN_TRANS_WIDTH = 2
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  input  logic [MASTERID_WIDTH-1:0]   currTransID,
  input  logic [NUM_SLAVES_WIDTH-1:0] currTransSlaveID,
  input  logic                        openTransInc,
  input  logic                        openTransDec,
  input  logic [MASTERID_WIDTH-1:0]   openTransDecID,
  output logic                        threadAvail,
  output logic                        threadValid,
  output logic [OPEN_TRANS_WIDTH-1:0] threadCount,
  output logic [NUM_SLAVES_WIDTH-1:0] threadSlaveID,
  output logic                        openTransAny,
  output logic                        trackErr
);

  localparam logic [OPEN_TRANS_WIDTH-1:0] MAX_CNT = OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX);
  localparam logic [OPEN_TRANS_WIDTH-1:0] ONE_CNT = OPEN_TRANS_WIDTH'(1);

  // Slot state
  logic [NUM_THREADS-1:0]                       valid_q, valid_d;
  logic [NUM_THREADS-1:0][MASTERID_WIDTH-1:0]   id_q, id_d;
  logic [NUM_THREADS-1:0][NUM_SLAVES_WIDTH-1:0] slave_q, slave_d;
  logic [NUM_THREADS-1:0][OPEN_TRANS_WIDTH-1:0] cnt_q, cnt_d;
  logic                                         err_q, err_d;

  // Per-slot decode of the current request and of the completing ID
  logic [NUM_THREADS-1:0] cur_match;
  logic [NUM_THREADS-1:0] dec_match;
  logic [NUM_THREADS-1:0] alloc_oh;   // lowest-index free slot, one-hot
  logic                   alloc_found;
  logic                   cur_hit;
  logic                   hit_ok;
  logic [NUM_THREADS-1:0] inc_upd;
  logic [NUM_THREADS-1:0] inc_alloc;
  logic [NUM_THREADS-1:0] dec_apply;
  logic                   inc_err;
  logic                   dec_err;

  // Lookup: zero latency from registered state. Valid IDs are unique, so at
  // most one slot matches and an AND-OR mux is enough.
  always_comb begin
    cur_match     = '0;
    dec_match     = '0;
    threadCount   = '0;
    threadSlaveID = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      cur_match[i]  = valid_q[i] && (id_q[i] == currTransID);
      dec_match[i]  = valid_q[i] && (id_q[i] == openTransDecID);
      threadCount   = threadCount   | (cnt_q[i]   & {OPEN_TRANS_WIDTH{cur_match[i]}});
      threadSlaveID = threadSlaveID | (slave_q[i] & {NUM_SLAVES_WIDTH{cur_match[i]}});
    end
  end

  assign threadValid  = |cur_match;
  assign threadAvail  = ~(&valid_q);
  assign openTransAny = |valid_q;
  assign trackErr     = err_q;

  // Allocation only looks at slots free at the start of the cycle, so a slot
  // released by a simultaneous dec cannot be taken in the same cycle.
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  // Request qualification. The count check uses the pre-dec value, so an inc
  // at the maximum is refused even if the same ID completes this cycle.
  always_comb begin
    cur_hit   = threadValid;
    hit_ok    = cur_hit && (threadSlaveID == currTransSlaveID) && (threadCount < MAX_CNT);
    inc_upd   = cur_match & {NUM_THREADS{openTransInc && hit_ok}};
    inc_alloc = alloc_oh  & {NUM_THREADS{openTransInc && !cur_hit}};
    dec_apply = dec_match & {NUM_THREADS{openTransDec}};
    inc_err   = openTransInc && (cur_hit ? !hit_ok : !alloc_found);
    dec_err   = openTransDec && !(|dec_match);
  end

  // Next-state per slot. inc_alloc targets a free slot and dec_apply a valid
  // one, so those two never coincide on the same slot.
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    slave_d = slave_q;
    cnt_d   = cnt_q;
    err_d   = err_q || inc_err || dec_err;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (inc_alloc[i]) begin
        valid_d[i] = 1'b1;
        id_d[i]    = currTransID;
        slave_d[i] = currTransSlaveID;
        cnt_d[i]   = ONE_CNT;
      end else if (inc_upd[i] && dec_apply[i]) begin
        // Accepted inc and completing dec on the same slot cancel out; the
        // slot stays open even when its count is 1.
        cnt_d[i] = cnt_q[i];
      end else if (inc_upd[i]) begin
        cnt_d[i] = cnt_q[i] + ONE_CNT;
      end else if (dec_apply[i]) begin
        if (cnt_q[i] > ONE_CNT) begin
          cnt_d[i] = cnt_q[i] - ONE_CNT;
        end else begin
          // id and slave are left stale; they are ignored while invalid.
          valid_d[i] = 1'b0;
          cnt_d[i]   = '0;
        end
      end
    end
  end

  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset) begin
      valid_q <= '0;
      id_q    <= '0;
      slave_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      slave_q <= slave_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
